pc_sequencer: RTL and testbench

//   Multi-cycle control FSM that sequences program_counter and the fetch/memory/writeback path of the RV32I core.

---
 rtl/pc_sequencer_if.sv | 46 ++++
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Handshake and control bundle between pc_sequencer and the RV32I datapath/memories.
// The master side is the sequencer; the slave side is datapath, program_counter and memories.
interface pc_sequencer_if;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       imem_ack;
  logic       dmem_ack;
  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic       ir_load;
  logic       rf_we;
  logic [3:0] pc_control;
  logic       halted;
  logic [2:0] state_dbg;

  modport master (
    input  opcode,
    input  branch_taken,
    input  imem_ack,
    input  dmem_ack,
    output imem_req,
    output dmem_req,
    output dmem_we,
    output ir_load,
    output rf_we,
    output pc_control,
    output halted,
    output state_dbg
  );

  modport slave (
    output opcode,
    output branch_taken,
    output imem_ack,
    output dmem_ack,
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    input  ir_load,
    input  rf_we,
    input  pc_control,
    input  halted,
    input  state_dbg
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXECUTE -> [MEM] -> WB, one instruction per pass.
// Optional macro ILLEGAL_OP_TRAP_EN: illegal opcodes halt the core instead of executing as NOP.
module pc_sequencer #(
  parameter int unsigned RESET_HOLD_CYCLES = 2  // legal range 1..15
) (
  input  logic          clk,
  input  logic          reset_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StRstHold = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExecute = 3'd3,
    StMem     = 3'd4,
    StWb      = 3'd5,
    StHalt    = 3'd6
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;
`endif

  localparam logic [3:0] HoldLast = 4'(RESET_HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       pc_reset_q, pc_reset_d;
  logic [6:0] opcode_q, opcode_d;

  function automatic logic writes_rf(input logic [6:0] op);
    case (op)
      OpOp, OpOpImm, OpLoad, OpLui, OpAuipc, OpJal, OpJalr: writes_rf = 1'b1;
      default:                                              writes_rf = 1'b0;
    endcase
  endfunction

`ifdef ILLEGAL_OP_TRAP_EN
  function automatic logic is_base_op(input logic [6:0] op);
    case (op)
      OpLoad, OpStore, OpOp, OpOpImm, OpLui, OpAuipc,
      OpJal, OpJalr, OpBranch, OpFence, OpSystem: is_base_op = 1'b1;
      default:                                    is_base_op = 1'b0;
    endcase
  endfunction
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StRstHold;
      hold_cnt_q <= 4'd0;
      pc_reset_q <= 1'b1;
      opcode_q   <= 7'd0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pc_reset_q <= pc_reset_d;
      opcode_q   <= opcode_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    opcode_d   = opcode_q;
    unique case (state_q)
      StRstHold: begin
        if (hold_cnt_q == HoldLast) begin
          state_d = StFetch;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      StFetch: begin
        if (bus.imem_ack) state_d = StDecode;
      end
      StDecode: begin
        opcode_d = bus.opcode;
`ifdef ILLEGAL_OP_TRAP_EN
        state_d  = is_base_op(bus.opcode) ? StExecute : StHalt;
`else
        state_d  = StExecute;
`endif
      end
      StExecute: begin
        state_d = ((opcode_q == OpLoad) || (opcode_q == OpStore)) ? StMem : StWb;
      end
      StMem: begin
        if (bus.dmem_ack) state_d = StWb;
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StRstHold;
    endcase
    // PC reset is registered so the async reset into program_counter cannot glitch.
    pc_reset_d = (state_d == StRstHold);
  end

  always_comb begin
    bus.imem_req   = 1'b0;
    bus.ir_load    = 1'b0;
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.rf_we      = 1'b0;
    bus.pc_control = {pc_reset_q, 3'b000};
    unique case (state_q)
      StFetch: begin
        bus.imem_req = 1'b1;
        bus.ir_load  = bus.imem_ack;
      end
      StMem: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (opcode_q == OpStore);
      end
      StWb: begin
        bus.rf_we         = writes_rf(opcode_q);
        bus.pc_control[2] = 1'b1;
        bus.pc_control[1] = (opcode_q == OpJal) || ((opcode_q == OpBranch) && bus.branch_taken);
        bus.pc_control[0] = (opcode_q == OpJalr);
      end
      default: ;
    endcase
`ifdef ILLEGAL_OP_TRAP_EN
    bus.halted = (state_q == StHalt);
`else
    bus.halted = 1'b0;
`endif
    bus.state_dbg = state_q;
  end

  a_pc_enable_only_wb : assert property (@(posedge clk) disable iff (!reset_n)
    bus.pc_control[2] |-> (state_q == StWb));
  a_req_exclusive : assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.imem_req && bus.dmem_req));
  a_pc_reset_only_hold : assert property (@(posedge clk) disable iff (!reset_n)
    bus.pc_control[3] |-> (state_q == StRstHold));

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a per-instruction trace model predicts every cycle's outputs.
// Honors ILLEGAL_OP_TRAP_EN the same way as the design.
module tb_pc_sequencer;

  localparam int unsigned Hold = 2;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpBad    = 7'b1111111;

`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_HOLD_CYCLES(Hold)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // One record per clock: inputs to drive and outputs expected in that cycle.
  typedef struct {
    logic        rst_n;
    logic        iack;
    logic        dack;
    logic        bt;
    logic [6:0]  op;
    logic [12:0] exp;  // {imem_req, dmem_req, dmem_we, ir_load, rf_we, pc_control, halted, state}
    bit          lv;
    logic [4:0]  lit;  // hand-computed {rf_we, pc_control} for the WB cycle
  } cyc_t;

  cyc_t        sched[$];
  cyc_t        cur;
  bit          cur_valid = 1'b0;
  int          cyc_idx = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [12:0] act;

  function automatic logic [12:0] ev(input logic ireq, input logic dreq, input logic dwe,
                                     input logic irl, input logic rfw, input logic [3:0] pc,
                                     input logic hlt, input logic [2:0] st);
    return {ireq, dreq, dwe, irl, rfw, pc, hlt, st};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    logic [6:0] base [11] = '{OpLoad, OpStore, OpOp, OpOpImm, OpLui, OpAuipc,
                              OpJal, OpJalr, OpBranch, OpFence, OpSystem};
    foreach (base[i]) if (base[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit writes_rf(input logic [6:0] op);
    return op inside {OpOp, OpOpImm, OpLoad, OpLui, OpAuipc, OpJal, OpJalr};
  endfunction

  task automatic push(input logic rst_n, input logic iack, input logic dack, input logic bt,
                      input logic [6:0] op, input logic [12:0] e,
                      input bit lv = 1'b0, input logic [4:0] lit = 5'd0);
    cyc_t c;
    c.rst_n = rst_n;
    c.iack  = iack;
    c.dack  = dack;
    c.bt    = bt;
    c.op    = op;
    c.exp   = e;
    c.lv    = lv;
    c.lit   = lit;
    sched.push_back(c);
  endtask

  task automatic do_reset();
    repeat (2) push(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, ev(0, 0, 0, 0, 0, 4'b1000, 0, 3'd0));
    repeat (Hold) push(1'b1, 1'b1, 1'b1, 1'b0, 7'd0, ev(0, 0, 0, 0, 0, 4'b1000, 0, 3'd0));
  endtask

  // Expected trace of one instruction; abort >= 0 stops after that many MEM wait cycles.
  task automatic instr(input logic [6:0] op, input logic bt, input int iw, input int dw,
                       input logic [4:0] lit, input int abort = -1);
    logic [6:0] junk;
    bit         mem;
    bit         st;
    logic [3:0] wb_pc;
    junk  = ~op;
    mem   = (op == OpLoad) || (op == OpStore);
    st    = (op == OpStore);
    wb_pc = {2'b01, (op == OpJal) || ((op == OpBranch) && bt), (op == OpJalr)};
    for (int i = 0; i < iw; i++) push(1'b1, 1'b0, 1'b1, ~bt, junk, ev(1, 0, 0, 0, 0, 4'd0, 0, 3'd1));
    push(1'b1, 1'b1, 1'b0, ~bt, junk, ev(1, 0, 0, 1, 0, 4'd0, 0, 3'd1));
    push(1'b1, 1'b1, 1'b1, ~bt, op, ev(0, 0, 0, 0, 0, 4'd0, 0, 3'd2));
    if (TrapEn && !is_legal(op)) begin
      repeat (4) push(1'b1, 1'b1, 1'b1, bt, junk, ev(0, 0, 0, 0, 0, 4'd0, 1, 3'd6));
      return;
    end
    push(1'b1, 1'b1, 1'b1, ~bt, junk, ev(0, 0, 0, 0, 0, 4'd0, 0, 3'd3));
    if (mem) begin
      for (int i = 0; i < dw; i++) begin
        if (abort == i) return;
        push(1'b1, 1'b1, 1'b0, ~bt, junk, ev(0, 1, st, 0, 0, 4'd0, 0, 3'd4));
      end
      push(1'b1, 1'b1, 1'b1, ~bt, junk, ev(0, 1, st, 0, 0, 4'd0, 0, 3'd4));
    end
    push(1'b1, 1'b0, 1'b1, bt, junk,
         ev(0, 0, 0, 0, writes_rf(op), wb_pc, 0, 3'd5), 1'b1, lit);
  endtask

  initial begin
    bus.opcode       = 7'd0;
    bus.branch_taken = 1'b0;
    bus.imem_ack     = 1'b0;
    bus.dmem_ack     = 1'b0;
    #1 reset_n = 1'b0;

    do_reset();
    instr(OpOpImm,  1'b0, 3, 0, 5'b1_0100);
    instr(OpBranch, 1'b1, 0, 0, 5'b0_0110);
    instr(OpBranch, 1'b0, 1, 0, 5'b0_0100);
    instr(OpJalr,   1'b0, 0, 0, 5'b1_0101);
    instr(OpJal,    1'b1, 2, 0, 5'b1_0110);
    instr(OpStore,  1'b0, 0, 5, 5'b0_0100);
    instr(OpLoad,   1'b1, 1, 0, 5'b1_0100);
    instr(OpLui,    1'b0, 0, 0, 5'b1_0100);
    instr(OpFence,  1'b1, 0, 0, 5'b0_0100);
    instr(OpSystem, 1'b0, 2, 0, 5'b0_0100);
    instr(OpLoad,   1'b0, 0, 4, 5'b1_0100, 2);
    push(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, ev(0, 0, 0, 0, 0, 4'b1000, 0, 3'd0));
    do_reset();
    instr(OpAuipc,  1'b0, 0, 0, 5'b1_0100);
    instr(OpOp,     1'b1, 1, 0, 5'b1_0100);
    instr(OpBad,    1'b0, 0, 0, 5'b0_0100);
    do_reset();
    instr(OpOpImm,  1'b0, 0, 0, 5'b1_0100);

    foreach (sched[i]) begin
      @(posedge clk);
      #1;
      reset_n          = sched[i].rst_n;
      bus.imem_ack     = sched[i].iack;
      bus.dmem_ack     = sched[i].dack;
      bus.branch_taken = sched[i].bt;
      bus.opcode       = sched[i].op;
      cur              = sched[i];
      cyc_idx          = i;
      cur_valid        = 1'b1;
    end
    @(posedge clk);
    #1 cur_valid = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cur_valid) begin
        act = {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_load, bus.rf_we,
               bus.pc_control, bus.halted, bus.state_dbg};
        n_cmp++;
        if (act !== cur.exp) begin
          n_bad++;
          $display("FAIL cycle %0d outputs {ireq,dreq,dwe,irl,rfw,pc,hlt,st}: got %b want %b",
                   cyc_idx, act, cur.exp);
        end
        if (cur.lv) begin
          n_cmp++;
          if ({bus.rf_we, bus.pc_control} !== cur.lit) begin
            n_bad++;
            $display("FAIL cycle %0d wb_literal {rf_we,pc_control}: got %b want %b",
                     cyc_idx, {bus.rf_we, bus.pc_control}, cur.lit);
          end
        end
      end
    end
  end

endmodule
